// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences one shared ALU and memory over 3-5 cycles per instruction.
module multicycle_ctrl #(
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_q;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_d;
    logic       regwrite_d;
    logic       memwrite_d;
    logic [2:0] funct_alu;

    // State register; op only steers the DECODE and MEMADR branches
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:   state_q <= DECODE;
                DECODE: begin
                    if (op == OP_LW || op == OP_SW) state_q <= MEMADR;
                    else if (op == OP_RTYPE)        state_q <= RTYPEEX;
                    else if (op == OP_BEQ)          state_q <= BEQEX;
                    else if (op == OP_ADDI)         state_q <= ADDIEX;
                    else if (op == OP_J)            state_q <= JEX;
                    else                            state_q <= FETCH;
                end
                MEMADR: begin
                    if (op == OP_SW) state_q <= MEMWR;
                    else             state_q <= MEMRD;
                end
                MEMRD:   state_q <= MEMWB;
                RTYPEEX: state_q <= RTYPEWB;
                ADDIEX:  state_q <= ADDIWB;
                default: state_q <= FETCH;
            endcase
        end
    end

    // R-type ALU operation from funct; unknown functs fall back to add
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    end

    // Moore decode of datapath controls; everything defaults to 0
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_d  = 1'b0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (state_q)
            FETCH: begin
                irwrite_d  = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_d = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_d = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_d = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            ADDIWB: begin
                regwrite_d = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                pcwrite = 1'b0;
            end
        endcase
    end

    // Reset masks every architectural write so an abandoned instruction
    // cannot commit anything at the reset edge
    always_comb begin
        pcen     = ~reset & (pcwrite | (branch & zero));
        irwrite  = ~reset & irwrite_d;
        regwrite = ~reset & regwrite_d;
        memwrite = ~reset & memwrite_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues one hand-written
// expected output vector per cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite;
    logic       iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Vector layout: state, pcen irwrite regwrite memwrite iord memtoreg
    // regdst alusrca, alusrcb, pcsrc, alucontrol
    function automatic logic [18:0] actual();
        return {state, pcen, irwrite, regwrite, memwrite, iord, memtoreg,
                regdst, alusrca, alusrcb, pcsrc, alucontrol};
    endfunction

    // Monitor: one comparison per cycle whenever an expectation is pending
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [18:0] a;
            e = q.pop_front();
            a = actual();
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL %s: got st=%0d en=%b asb=%b pcs=%b alu=%b, want st=%0d en=%b asb=%b pcs=%b alu=%b",
                         e.name, a[18:15], a[14:7], a[6:5], a[4:3], a[2:0],
                         e.v[18:15], e.v[14:7], e.v[6:5], e.v[4:3], e.v[2:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for it
    task automatic cyc(input string nm, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic [3:0] st,
                       input logic [7:0] en, input logic [1:0] asb,
                       input logic [1:0] pcs, input logic [2:0] alu);
        exp_t e;
        reset = rst;
        op    = o;
        funct = f;
        zero  = z;
        e.name = nm;
        e.v    = {st, en, asb, pcs, alu};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
        $fatal(1, "timeout");
    end

    localparam logic [5:0] FN [5] = '{6'b100000, 6'b100010, 6'b100100,
                                      6'b100101, 6'b000111};
    localparam logic [2:0] AL [5] = '{3'b010, 3'b110, 3'b000,
                                      3'b001, 3'b010};

    initial begin
        reset = 1'b1;
        op    = SW;
        funct = 6'd0;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        // reset held: state FETCH, writes masked, muxes still follow FETCH
        cyc("rst0", 1, SW, 0, 0, 4'd0, 8'b0000_0000, 2'b01, 2'b00, 3'b010);
        cyc("rst1", 1, SW, 0, 1, 4'd0, 8'b0000_0000, 2'b01, 2'b00, 3'b010);
        // lw, with op garbage outside DECODE/MEMADR
        cyc("lw_f",  0, BAD, 0, 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("lw_d",  0, LW,  0, 0, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("lw_ma", 0, LW,  0, 0, 4'd2, 8'b0000_0001, 2'b10, 2'b00, 3'b010);
        cyc("lw_mr", 0, SW,  0, 0, 4'd3, 8'b0000_1000, 2'b00, 2'b00, 3'b000);
        cyc("lw_wb", 0, BAD, 0, 0, 4'd4, 8'b0010_0100, 2'b00, 2'b00, 3'b000);
        // slt
        cyc("slt_f",  0, RT, 6'b101010, 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("slt_d",  0, RT, 6'b101010, 0, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("slt_ex", 0, RT, 6'b101010, 0, 4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b111);
        cyc("slt_wb", 0, RT, 6'b101010, 0, 4'd7, 8'b0010_0010, 2'b00, 2'b00, 3'b000);
        // remaining funct codes, incl. an unknown one, in RTYPEEX
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("rt%0d_f", i),  0, RT, FN[i], 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
            cyc($sformatf("rt%0d_d", i),  0, RT, FN[i], 0, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
            cyc($sformatf("rt%0d_ex", i), 0, RT, FN[i], 0, 4'd6, 8'b0000_0001, 2'b00, 2'b00, AL[i]);
            cyc($sformatf("rt%0d_wb", i), 0, RT, FN[i], 0, 4'd7, 8'b0010_0010, 2'b00, 2'b00, 3'b000);
        end
        // beq taken then not taken
        cyc("beq1_f",  0, BEQ, 0, 1, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("beq1_d",  0, BEQ, 0, 1, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("beq1_ex", 0, BEQ, 0, 1, 4'd8, 8'b1000_0001, 2'b00, 2'b01, 3'b110);
        cyc("beq0_f",  0, BEQ, 0, 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("beq0_d",  0, BEQ, 0, 0, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("beq0_ex", 0, BEQ, 0, 0, 4'd8, 8'b0000_0001, 2'b00, 2'b01, 3'b110);
        // jump
        cyc("j_f",  0, J, 0, 0, 4'd0,  8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("j_d",  0, J, 0, 0, 4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("j_ex", 0, J, 0, 0, 4'd11, 8'b1000_0000, 2'b00, 2'b10, 3'b000);
        // unknown opcode acts as a 2-cycle nop
        cyc("nop_f", 0, BAD, 0, 1, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("nop_d", 0, BAD, 0, 1, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        // addi
        cyc("addi_f",  0, ADDI, 0, 0, 4'd0,  8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("addi_d",  0, ADDI, 0, 0, 4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("addi_ex", 0, ADDI, 0, 0, 4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010);
        cyc("addi_wb", 0, ADDI, 0, 0, 4'd10, 8'b0010_0000, 2'b00, 2'b00, 3'b000);
        // sw abandoned by reset in MEMADR
        cyc("swr_f",  0, SW, 0, 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("swr_d",  0, SW, 0, 0, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("swr_ma", 1, SW, 0, 0, 4'd2, 8'b0000_0001, 2'b10, 2'b00, 3'b010);
        // full sw after recovery
        cyc("sw_f",  0, SW, 0, 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        cyc("sw_d",  0, SW, 0, 0, 4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010);
        cyc("sw_ma", 0, SW, 0, 0, 4'd2, 8'b0000_0001, 2'b10, 2'b00, 3'b010);
        cyc("sw_mw", 0, LW, 0, 0, 4'd5, 8'b0001_1000, 2'b00, 2'b00, 3'b000);
        cyc("end_f", 0, RT, 0, 0, 4'd0, 8'b1100_0000, 2'b01, 2'b00, 3'b010);
        #20;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath. It reuses one ALU and one memory across 3–5 cycles per instruction.
- Each cycle it drives the mux selects and write enables for PC, IR, register file and memory.
- ALUSrcB=11 selects the sign-extended immediate shifted left by 2, which is the branch offset.
- It covers lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- OP_LW, 6'b100011, lw opcode
- OP_SW, 6'b101011, sw opcode
- OP_RTYPE, 6'b000000, R-type opcode
- OP_BEQ, 6'b000100, beq opcode
- OP_ADDI, 6'b001000, addi opcode
- OP_J, 6'b000010, j opcode

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from IR
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC write enable = pcwrite | (branch & zero)
- irwrite  output  1  IR load enable
- regwrite  output  1  register file write enable
- memwrite  output  1  memory write enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  writeback select: 1 = memory data, 0 = ALUOut
- regdst  output  1  destination register: 1 = rd, 0 = rt
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU operation code
- state  output  4  current state, for debug and verification

Behaviour:
Clocking and reset
- One clock. Reset is synchronous and active-high.
- A reset sampled high forces state to FETCH (0) at that edge.
- While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0 combinationally. All other outputs follow the current state.
- Reset asserted mid-instruction abandons the instruction. No partial writeback occurs after the reset edge.

State encoding
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Codes 12–15 are illegal: all enables are 0 and the next state is FETCH.

Outputs
- Moore decode from state, except pcen (uses zero) and alucontrol in RTYPEEX (uses funct).
- Default for every output is 0; each state lists only its non-zero outputs.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, add.
- DECODE: alusrcb=11, add. ALUOut receives the branch target.
- MEMADR: alusrca=1, alusrcb=10, add.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, alusrcb=00, funct decode.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10, add.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.

ALU control codes
- add = 010, sub = 110.
- funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct→010.

Transitions
- FETCH→DECODE.
- DECODE: lw/sw→MEMADR, R-type→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX, any other opcode→FETCH (treated as a nop).
- MEMADR: lw→MEMRD, sw→MEMWR.
- MEMRD→MEMWB.
- RTYPEEX→RTYPEWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX all go to FETCH.
- op is sampled only in DECODE and MEMADR; op changing in other states has no effect.

Cycle counts (FETCH to return to FETCH)
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.

Test Plan:
- Reset: reset=1 for 2 cycles with op=OP_SW → state=0 and pcen=irwrite=regwrite=memwrite=0 throughout. After release, the first cycle shows irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op=100011) → state sequence 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0. memwrite=0 throughout.
- R-type slt (op=000000, funct=101010) → states 0,1,6,7,0. RTYPEEX has alucontrol=111. RTYPEWB has regwrite=1, regdst=1.
- beq, zero=1 then repeated with zero=0 → states 0,1,8,0 in both runs. In BEQEX, alucontrol=110 and pcsrc=01; pcen=1 in the zero=1 run, pcen=0 in the zero=0 run. DECODE shows alusrcb=11.
- j (000010) then op=111111 → j: states 0,1,11,0 with pcsrc=10, pcen=1. op=111111: states 0,1,0 with no write enable asserted in DECODE.
- sw with reset asserted during MEMADR → next state 0. memwrite never asserts. Normal fetch resumes after reset release.
